qr_frame_sequencer: RTL and testbench

//  Upstream-facing sequencer for the QR engine. Buffers one complete frame: 10 subcarriers x
//  (16 H words + 4 y words) = 200 words of 48 bits, from a valid/ready stream.

---
 rtl/qr_pkg.sv | 17 +
 rtl/qr_frame_buf.sv | 33 +++
 rtl/qr_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_qr_frame_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared constants and types for the QR frame sequencer.
//   DATA_W       width of one H/y word
//   FRAME_WORDS  words per frame replayed to the engine
//   RESULTS      result strobes expected per frame
//   TIMEOUT      cycles allowed in WAIT_OUT before giving up
package qr_pkg;
  localparam int DATA_W      = 48;
  localparam int FRAME_WORDS = 200;
  localparam int RESULTS     = 10;
  localparam int TIMEOUT     = 1024;

  localparam int ADDR_W = $clog2(FRAME_WORDS);
  localparam int RES_W  = $clog2(RESULTS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, WAIT_OUT} rd_state_t;
endpackage

// File: rtl/qr_frame_buf.sv
// Simple dual-port frame buffer, DEPTH x DW.
//   i_clk, i_rst      clock, sync active-high reset (clears read register only)
//   i_we/i_waddr/i_wdata  synchronous write port
//   i_re/i_raddr      read request; data appears on o_rdata one cycle later
//   o_rdata           registered read data, holds when i_re is low
module qr_frame_buf #(
  parameter int DW    = 48,
  parameter int DEPTH = 200,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     rdata_q <= '0;
    else if (i_re) rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;
endmodule

// File: rtl/qr_frame_sequencer.sv
// Upstream-facing sequencer for the QR engine. Buffers one full frame from a
// valid/ready stream, replays it as an unbroken burst (engine has no
// backpressure), then tracks result strobes until end-of-frame or timeout.
//   i_clk, i_rst                 clock, sync active-high reset
//   i_in_vld/i_in_data/o_in_rdy  upstream word stream
//   o_trig/o_data                engine feed, o_trig high while o_data valid
//   i_rd_vld/i_last_data         engine result / end-of-frame strobes
//   o_busy                       burst or result wait in progress
//   o_frame_done/o_err           1-cycle status pulses
// Optional: QR_SEQ_STATS_EN adds o_frame_cnt/o_err_cnt saturating counters.
module qr_frame_sequencer
  import qr_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_vld,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_rdy,
  output logic              o_trig,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_rd_vld,
  input  logic              i_last_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err
`ifdef QR_SEQ_STATS_EN
  ,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_err_cnt
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [RES_W-1:0]  RES_MAX   = RES_W'(RESULTS);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT - 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, rd_cnt_q, rd_cnt_d, rd_addr;
  logic [RES_W-1:0]  res_cnt_q, res_cnt_d, res_sum;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              buf_full_q, rd_en, accept, stream_last;
  logic              done_q, done_d, err_q, err_d;

  assign o_in_rdy     = ~buf_full_q & (state_q != STREAM);
  assign accept       = i_in_vld & o_in_rdy;
  assign stream_last  = (state_q == STREAM) && (rd_cnt_q == LAST_ADDR);
  assign o_trig       = (state_q == STREAM);
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = done_q;
  assign o_err        = err_q;

  // Write side. buf_full releases on the last streamed word so the next
  // frame can fill while the engine is still producing results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_cnt_q   <= '0;
      buf_full_q <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_cnt_q == LAST_ADDR) begin
          wr_cnt_q   <= '0;
          buf_full_q <= 1'b1;
        end else begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
      if (stream_last) buf_full_q <= 1'b0;
    end
  end

  qr_frame_buf #(.DW(DATA_W), .DEPTH(FRAME_WORDS), .AW(ADDR_W)) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (accept),
    .i_waddr (wr_cnt_q),
    .i_wdata (i_in_data),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (o_data)
  );

  assign res_sum = res_cnt_q + {{(RES_W-1){1'b0}}, i_rd_vld};

  // Read FSM. The RAM read runs one word ahead of o_trig: PRIME fetches
  // word 0, and STREAM cycle k fetches word k+1 while word k is on o_data.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    res_cnt_d = res_cnt_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (buf_full_q) state_d = PRIME;
      PRIME: begin
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_cnt_d = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        if (rd_cnt_q == LAST_ADDR) begin
          state_d   = WAIT_OUT;
          res_cnt_d = '0;
          tmo_d     = '0;
        end else begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      WAIT_OUT: begin
        if (i_last_data) begin
          if (res_sum == RES_MAX) done_d = 1'b1;
          else                    err_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (i_rd_vld) begin
            if (res_cnt_q == RES_MAX) err_d = 1'b1;  // surplus result
            else                      res_cnt_d = res_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      res_cnt_q <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      res_cnt_q <= res_cnt_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef QR_SEQ_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (done_q && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q && err_cnt_q != 16'hFFFF)    err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_qr_frame_sequencer.sv
module tb_qr_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic [47:0] in_data = '0;
  logic        in_rdy, trig, busy, frame_done, err;
  logic [47:0] data;
  logic        rd_vld = 1'b0;
  logic        last_data = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [47:0] cap [300];
  int cap_n;
  int lat;

  always #5 clk = ~clk;

  qr_frame_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_vld     (in_vld),
    .i_in_data    (in_data),
    .o_in_rdy     (in_rdy),
    .o_trig       (trig),
    .o_data       (data),
    .i_rd_vld     (rd_vld),
    .i_last_data  (last_data),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_err        (err)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Push 200 words base..base+199, honouring o_in_rdy. Returns right after
  // the edge that accepted the last word.
  task automatic push_frame(input int base);
    int k = 0;
    int guard = 0;
    logic r;
    while (k < 200 && guard < 3000) begin
      in_vld  = 1'b1;
      in_data = 48'(base + k);
      r = in_rdy;
      tick();
      if (r) k++;
      guard++;
    end
    in_vld = 1'b0;
  endtask

  // Count edges until o_trig, then record words while o_trig stays high.
  task automatic grab_burst;
    lat = 0;
    cap_n = 0;
    while (!trig && lat < 50) begin tick(); lat++; end
    while (trig && cap_n < 300) begin
      cap[cap_n] = data;
      cap_n++;
      tick();
    end
  endtask

  // Engine model: nres result strobes on alternate cycles, then last_data.
  task automatic engine(input int nres, output int errs);
    errs = 0;
    for (int i = 0; i < nres; i++) begin
      rd_vld = 1'b1; tick(); rd_vld = 1'b0;
      if (err) errs++;
      tick();
      if (err) errs++;
    end
    last_data = 1'b1; tick(); last_data = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", in_rdy); end
    checks++; if (trig !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b exp=0", trig); end
    checks++; if (data !== 48'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", data); end
    checks++; if ({busy, frame_done, err} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {busy, frame_done, err}); end
  endtask

  task automatic test_fill_stream;
    int bad = 0;
    push_frame(0);
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL fill_rdy_drop got=%b exp=0", in_rdy); end
    grab_burst();
    checks++; if (lat !== 2) begin failures++; $display("FAIL fill_latency got=%0d exp=2", lat); end
    checks++; if (cap_n !== 200) begin failures++; $display("FAIL fill_burst_len got=%0d exp=200", cap_n); end
    for (int i = 0; i < 200 && i < cap_n; i++)
      if (cap[i] !== 48'(i)) begin
        if (bad == 0) $display("FAIL fill_data idx=%0d got=%0d exp=%0d", i, cap[i], i);
        bad++;
      end
    checks++; if (bad != 0) failures++;
    checks++; if ({busy, in_rdy} !== 2'b11) begin failures++; $display("FAIL wait_busy_rdy got=%b exp=11", {busy, in_rdy}); end
  endtask

  task automatic test_results;
    int errs;
    engine(10, errs);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", frame_done); end
    checks++; if ((errs != 0) || err !== 1'b0) begin failures++; $display("FAIL done_err errs=%0d err=%b exp=0", errs, err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%b exp=0", busy); end
    tick();
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", frame_done); end
  endtask

  task automatic test_back_to_back;
    int errs;
    int bad = 0;
    push_frame(0);
    grab_burst();
    push_frame(200);
    checks++; if ({trig, busy, in_rdy} !== 3'b010) begin failures++; $display("FAIL b2b_hold got=%b exp=010", {trig, busy, in_rdy}); end
    engine(10, errs);
    checks++; if (frame_done !== 1'b1 || errs != 0) begin failures++; $display("FAIL b2b_done1 got=%b errs=%0d exp=1/0", frame_done, errs); end
    grab_burst();
    checks++; if (lat !== 2 || cap_n !== 200) begin failures++; $display("FAIL b2b_burst lat=%0d len=%0d exp=2/200", lat, cap_n); end
    for (int i = 0; i < 200 && i < cap_n; i++)
      if (cap[i] !== 48'(200 + i)) begin
        if (bad == 0) $display("FAIL b2b_data idx=%0d got=%0d exp=%0d", i, cap[i], 200 + i);
        bad++;
      end
    checks++; if (bad != 0) failures++;
    engine(10, errs);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", frame_done); end
  endtask

  task automatic test_short_results;
    int errs;
    int bad = 0;
    push_frame(500);
    grab_burst();
    engine(9, errs);
    checks++; if ({err, frame_done} !== 2'b10) begin failures++; $display("FAIL short_err got=%b exp=10", {err, frame_done}); end
    tick();
    push_frame(700);
    grab_burst();
    checks++; if (lat !== 2 || cap_n !== 200) begin failures++; $display("FAIL short_next lat=%0d len=%0d exp=2/200", lat, cap_n); end
    for (int i = 0; i < 200 && i < cap_n; i++)
      if (cap[i] !== 48'(700 + i)) begin
        if (bad == 0) $display("FAIL short_next_data idx=%0d got=%0d exp=%0d", i, cap[i], 700 + i);
        bad++;
      end
    checks++; if (bad != 0) failures++;
    engine(10, errs);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL short_next_done got=%b exp=1", frame_done); end
  endtask

  task automatic test_timeout;
    int first = -1;
    push_frame(900);
    grab_burst();
    for (int t = 1; t <= 1100 && first < 0; t++) begin
      tick();
      if (err) first = t;
    end
    checks++; if (first !== 1024) begin failures++; $display("FAIL timeout_cycle got=%0d exp=1024", first); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle got=%b exp=0", busy); end
  endtask

  task automatic test_mid_reset;
    int errs;
    int bad = 0;
    int seen = 0;
    tick();
    push_frame(0);
    lat = 0;
    while (!trig && lat < 50) begin tick(); lat++; end
    for (int i = 0; i < 100; i++) tick();
    checks++; if (trig !== 1'b1 || data !== 48'd100) begin failures++; $display("FAIL midrst_pre trig=%b data=%0d exp=1/100", trig, data); end
    rst = 1'b1; tick();
    checks++; if ({trig, busy, frame_done, err, in_rdy} !== 5'b00001 || data !== 48'd0) begin
      failures++; $display("FAIL midrst_outputs got=%b data=%0d exp=00001/0", {trig, busy, frame_done, err, in_rdy}, data);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (trig) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", seen); end
    push_frame(2000);
    grab_burst();
    checks++; if (lat !== 2 || cap_n !== 200) begin failures++; $display("FAIL midrst_fresh lat=%0d len=%0d exp=2/200", lat, cap_n); end
    for (int i = 0; i < 200 && i < cap_n; i++)
      if (cap[i] !== 48'(2000 + i)) begin
        if (bad == 0) $display("FAIL midrst_data idx=%0d got=%0d exp=%0d", i, cap[i], 2000 + i);
        bad++;
      end
    checks++; if (bad != 0) failures++;
    engine(10, errs);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL midrst_done got=%b exp=1", frame_done); end
  endtask

  initial begin
    test_reset();
    test_fill_stream();
    test_results();
    test_back_to_back();
    test_short_results();
    test_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
